// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
// UART transmitter: start bit, LSB-first data, optional parity (UART_TX_PARITY_EN), stop bit(s).
// One cycle from accept to start bit; tx_start is ignored while tx_busy is high (no queuing).
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 baurd_clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [PW-1:0] PS_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_serializer: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 2) begin : g_bad_oversample
    $error("uart_tx_serializer: OVERSAMPLE must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
  end

  logic [2:0]           state_q, state_d;
  logic [PW-1:0]        ps_q, ps_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_q, stop_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap;
`ifdef UART_TX_PARITY_EN
  // Untouched copy of the accepted byte; the shift register is consumed as bits go out.
  logic [DATA_BITS-1:0] data_q, data_d;
`endif

  assign wrap = (ps_q == PS_LAST);

  always_comb begin
    state_d = state_q;
    ps_d    = wrap ? '0 : ps_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    stop_d  = stop_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    data_d  = data_q;
`endif
    case (state_q)
      S_IDLE: begin
        ps_d   = '0;
        out_d  = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          data_d  = tx_data;
`endif
          state_d = S_START;
          out_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (wrap) begin
          state_d = S_DATA;
          idx_d   = '0;
          out_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            out_d   = (^data_q) ^ (PARITY_ODD != 0);
`else
            state_d = S_STOP;
            stop_d  = 1'b0;
            out_d   = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            out_d   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (wrap) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          out_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (wrap) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            out_d   = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge baurd_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ps_q    <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      stop_q  <= 1'b0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      data_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      data_q  <= data_d;
`endif
    end
  end

  assign tx_out  = out_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
// Scoreboarded bench: u_dut uses defaults (1 stop, even parity), u_dut2 uses 2 stop bits and odd parity.
module tb_uart_tx_serializer;

  localparam int OS = 16;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    logic [15:0] bits;
    int          nbits;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start2;
  logic [7:0] data1, data2;
  logic       out1, busy1, done1;
  logic       out2, busy2, done2;
  logic       mon_sel;
  logic       line, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  frame_t sb_q[$];

  always #5 clk = ~clk;

  uart_tx_serializer u_dut (
    .baurd_clk(clk), .reset(rst_n), .tx_start(start1), .tx_data(data1),
    .tx_out(out1), .tx_busy(busy1), .tx_done(done1)
  );

  uart_tx_serializer #(.STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
    .baurd_clk(clk), .reset(rst_n), .tx_start(start2), .tx_data(data2),
    .tx_out(out2), .tx_busy(busy2), .tx_done(done2)
  );

  assign line = mon_sel ? out2  : out1;
  assign busy = mon_sel ? busy2 : busy1;
  assign done = mon_sel ? done2 : done1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input int sb, input bit odd);
    frame_t f;
    int n;
    f.bits = '1;
    n = 0;
    f.bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      f.bits[n] = d[i]; n++;
    end
    if (PAR != 0) begin
      f.bits[n] = (^d) ^ odd; n++;
    end
    for (int s = 0; s < sb; s++) begin
      f.bits[n] = 1'b1; n++;
    end
    f.nbits = n;
    return f;
  endfunction

  // Called at a negedge; leaves the request asserted for exactly one rising edge.
  task automatic send(input bit sel, input logic [7:0] d, input bit push);
    if (push) sb_q.push_back(make_frame(d, sel ? 2 : 1, sel));
    if (sel) begin data2 = d; start2 = 1'b1; end
    else     begin data1 = d; start1 = 1'b1; end
    @(negedge clk);
    if (sel) start2 = 1'b0;
    else     start1 = 1'b0;
  endtask

  // Waits (bounded) for a start bit, checks the whole frame cycle by cycle, ends on the tx_done negedge.
  task automatic receive_frame(input string tag, output int waited);
    frame_t      f;
    logic [15:0] obs;
    int          glitch, busy_cnt, done_in;
    waited = 0;
    while (line !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (line !== 1'b0) begin
      check_eq({tag, "_start_timeout"}, {31'd0, line}, 32'd0);
      return;
    end
    if (sb_q.size() == 0) begin
      check_eq({tag, "_unexpected_frame"}, sb_q.size(), 32'd1);
      return;
    end
    f = sb_q.pop_front();
    obs = '1; glitch = 0; busy_cnt = 0; done_in = 0;
    for (int i = 0; i < f.nbits; i++) begin
      for (int k = 0; k < OS; k++) begin
        if (k == OS / 2) obs[i] = line;
        if (line !== f.bits[i]) glitch++;
        if (busy === 1'b1) busy_cnt++;
        if (done !== 1'b0) done_in++;
        @(negedge clk);
      end
    end
    check_eq({tag, "_bits"},      {16'd0, obs}, {16'd0, f.bits});
    check_eq({tag, "_glitches"},  glitch,   32'd0);
    check_eq({tag, "_busy_len"},  busy_cnt, f.nbits * OS);
    check_eq({tag, "_done_early"}, done_in, 32'd0);
    check_eq({tag, "_done_end"},  {31'd0, done}, 32'd1);
    check_eq({tag, "_busy_end"},  {31'd0, busy}, 32'd0);
    check_eq({tag, "_line_end"},  {31'd0, line}, 32'd1);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int dn, lo, bz;
    dn = 0; lo = 0; bz = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
      if (line !== 1'b1) lo++;
      if (busy !== 1'b0) bz++;
    end
    check_eq({tag, "_done_pulses"}, dn, 32'd0);
    check_eq({tag, "_line_low"},    lo, 32'd0);
    check_eq({tag, "_busy_high"},   bz, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w3, dn;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; data1 = '0; data2 = '0; mon_sel = 1'b0;
    @(negedge clk);
    check_eq("rst_out",  {31'd0, out1},  32'd1);
    check_eq("rst_busy", {31'd0, busy1}, 32'd0);
    check_eq("rst_done", {31'd0, done1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    quiet_window("idle", 50);

    send(1'b0, 8'hA5, 1'b1);
    receive_frame("a5", w);
    check_eq("a5_latency", w, 32'd0);
    @(negedge clk);
    check_eq("a5_done_width", {31'd0, done}, 32'd0);

`ifdef UART_TX_PARITY_EN
    send(1'b0, 8'h07, 1'b1);
    receive_frame("p07_even", w);
    mon_sel = 1'b1;
    send(1'b1, 8'hA5, 1'b1);
    receive_frame("pa5_odd", w);
    send(1'b1, 8'h07, 1'b1);
    receive_frame("p07_odd", w);
    mon_sel = 1'b0;
    @(negedge clk);
`endif

    // A start request mid-frame must be dropped, not queued.
    send(1'b0, 8'h3C, 1'b1);
    fork
      receive_frame("3c", w);
      begin
        repeat (39) @(negedge clk);
        data1 = 8'hFF; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
      end
    join
    quiet_window("after_3c", 200);
    check_eq("sb_drained_3c", sb_q.size(), 32'd0);

    mon_sel = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back(make_frame(8'h55, 2, 1'b1));
    data2 = 8'h55; start2 = 1'b1;
    @(negedge clk);
    receive_frame("held1", w);
    check_eq("held1_gap", w, 32'd0);
    receive_frame("held2", w);
    check_eq("held2_gap", w, 32'd1);
    fork
      receive_frame("held3", w3);
      begin
        repeat (3) @(negedge clk);
        start2 = 1'b0;
      end
    join
    check_eq("held3_gap", w3, 32'd1);
    quiet_window("after_held", 250);
    mon_sel = 1'b0;

    // Abort mid-frame: reset lands inside data bit 3 of 0xA5, which is low.
    data1 = 8'hA5; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (69) @(negedge clk);
    check_eq("pre_rst_line", {31'd0, line}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_out",  {31'd0, line}, 32'd1);
    check_eq("rst_async_busy", {31'd0, busy}, 32'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    check_eq("rst_done_pulses", dn, 32'd0);
    rst_n = 1'b1;
    quiet_window("post_rst_idle", 20);
    send(1'b0, 8'hA5, 1'b1);
    receive_frame("post_rst_a5", w);
    check_eq("post_rst_latency", w, 32'd0);
    check_eq("sb_drained_end", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmitter: the transmit-side counterpart of the receiver path.
- Accepts a parallel byte through a start/busy handshake and serialises it LSB-first onto a single line: start bit, data bits, optional parity, stop bit(s).
- Runs entirely on the oversampled baud clock. Bit timing comes from an internal prescaler, so no derived clock is needed.

Parameters:
- DATA_BITS, 8, payload width per frame; legal range 5..9.
- OVERSAMPLE, 16, baurd_clk cycles per serial bit; must be >= 2.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- baurd_clk  input  1  oversampled baud clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_start  input  1  request to send; sampled only in IDLE.
- tx_data  input  DATA_BITS  byte to send; captured on the edge that accepts tx_start.
- tx_out  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; tx_out=1, tx_busy=0, tx_done=0.
  - Prescaler, bit index and shift register are cleared.
  - Reset mid-frame aborts the frame immediately: tx_out returns high with no partial stop bit, and no tx_done pulse is generated.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Registered outputs only; tx_out has no combinational path from inputs.
- IDLE:
  - tx_out=1, tx_busy=0.
  - tx_start=1 at a rising edge: latch tx_data into the shift register, clear the prescaler, go to START.
  - From the following cycle: tx_out=0 and tx_busy=1. Accept-to-start-bit latency is 1 cycle.
- Prescaler: counts 0..OVERSAMPLE-1, then wraps. Each bit is held exactly OVERSAMPLE cycles. The state or bit advance happens on the wrap edge.
- START: after OVERSAMPLE cycles, go to DATA with bit index 0.
- DATA:
  - tx_out = shift register bit 0 (LSB first); shift right on each bit wrap.
  - Bit index counts 0..DATA_BITS-1 and is sized by clog2(DATA_BITS).
  - After the last data bit, go to PARITY if compiled in, else STOP.
- STOP: tx_out=1 for STOP_BITS*OVERSAMPLE cycles.
- Completion, on the wrap edge of the final stop bit:
  - state=IDLE; tx_busy=0; tx_done=1 for exactly one cycle.
  - tx_out stays 1.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) * OVERSAMPLE cycles, where P=1 with parity and 0 without.
- Handshake:
  - tx_start while tx_busy=1 is ignored; no queuing.
  - tx_data changes during a frame have no effect.
- Back-to-back: tx_start=1 in the same cycle tx_done=1 is accepted on the next edge. The next start bit then follows the last stop bit after one idle-high cycle.
- Held tx_start: a continuously asserted tx_start sends repeated frames, each with a one-cycle idle gap.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA and holds the parity bit for OVERSAMPLE cycles.
  - Parity = XOR of the latched data, inverted when PARITY_ODD=1.
  - Parity is computed from the copy latched at accept, not from the shifting register.
- Undefined:
  - No PARITY state or parity logic; DATA goes directly to STOP.
  - PARITY_ODD is ignored.

Test Plan:
- Reset then idle 50 cycles -> tx_out=1, tx_busy=0, tx_done=0 throughout.
- Defaults, no parity; tx_start pulse with tx_data=8'hA5:
  - Line reads 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
  - tx_busy high 160 cycles; tx_done single pulse at cycle 161 after accept.
- UART_TX_PARITY_EN, PARITY_ODD=0:
  - tx_data=8'hA5 -> parity bit 0; frame 176 cycles.
  - tx_data=8'h07 -> parity bit 1.
  - With PARITY_ODD=1 both parity bits invert.
- Send 8'h3C, then pulse tx_start with tx_data=8'hFF at cycle 40 -> ignored; only 8'h3C is transmitted and exactly one tx_done pulse occurs.
- Hold tx_start=1 with tx_data=8'h55, STOP_BITS=2 -> consecutive 176-cycle frames separated by exactly 1 idle-high cycle.
- Assert reset at cycle 70 of the 8'hA5 frame -> tx_out=1 asynchronously, no tx_done pulse; after release a new tx_start sends a full clean frame.
